mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access (M) stage load/store unit of the RV32IF pipeline. Consumes the EX/MEM register
//  outputs (ALUResultM as address, WriteDataM as store data, Rd/PC+4 pass around it) and drives
//  a ready/valid data-memory port with byte enables. Stalls the pipeline until the access completes
//  and delivers sign/zero-extended load data (incl. FLW word) toward the MEM/WB register.
// PARAMETERS
//  MAX_WAIT   255  max cycles in ACCESS waiting for dmem_ready before bus error (1..255)
// PORTS
//  clk          in   1   pipeline clock, rising edge
//  reset        in   1   asynchronous reset, active-low (0 = reset)
//  MemReadM     in   1   load (LB/LH/LW/LBU/LHU/FLW) in M stage
//  MemWriteM    in   1   store (SB/SH/SW/FSW) in M stage
//  Funct3M      in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM   in   32  effective byte address
//  WriteDataM   in   32  store data, LSB-aligned
//  dmem_req     out  1   memory request valid
//  dmem_we      out  1   1 = write, 0 = read
//  dmem_addr    out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_be      out  4   byte enables
//  dmem_ready   in   1   memory completes request this cycle
//  dmem_rdata   in   32  read data, valid with dmem_ready on reads
//  ReadDataM    out  32  extended load result, valid in DONE
//  StallM       out  1   freeze PC, IF/ID, ID/EX, EX/MEM
//  BusErrM      out  1   one-cycle pulse: MAX_WAIT timeout
//  MisalignM    out  1   one-cycle pulse: misaligned access (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE; dmem_req, dmem_we, StallM, BusErrM, MisalignM = 0; dmem_addr, dmem_wdata,
//   ReadDataM, wait counter = 0; dmem_be = 4'b0000. Reset mid-ACCESS drops dmem_req at once.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: MemReadM|MemWriteM -> StallM=1 combinationally same cycle; register addr/be/wdata/we,
//    go ACCESS. Both set -> write wins, read ignored. Neither -> stay, StallM=0.
//   ACCESS: dmem_req=1, StallM=1, req/addr/be/wdata/we held stable until dmem_ready.
//    dmem_ready=1 -> latch extended dmem_rdata (reads) to ReadDataM, go DONE.
//    else counter++; counter==MAX_WAIT-1 with no ready -> BusErrM pulse, ReadDataM=0, drop req, DONE.
//   DONE: StallM=0, dmem_req=0 for exactly one cycle; EX/MEM advances; -> IDLE (no re-issue).
//  Minimum latency: access seen in IDLE, ready in first ACCESS cycle -> DONE 2 cycles later.
//  Store lanes: B -> wdata={4{d[7:0]}}, be=4'b0001<<a[1:0]; H -> {2{d[15:0]}}, be=4'b0011<<{a[1],0};
//   W -> d, be=4'b1111. Reads drive be per size too.
//  Load extract: byte/half selected by a[1:0]/a[1]; B/H sign-extend, BU/HU zero-extend, W as-is.
//  Funct3 other than listed: treated as W.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no bus request; IDLE goes
//   straight to DONE (StallM=1 that IDLE cycle), MisalignM pulses in DONE, ReadDataM=0.
//  Undefined: low address bits below access size ignored (H uses a[1], W uses word), access
//   performed normally; MisalignM constant 0.
// STRUCTURE
//  Package mem_stage_pkg: Funct3 size/sign localparams, FSM state enum (IDLE/ACCESS/DONE),
//   byte-enable constants.
//  Sub-module mem_lane_align (combinational): store replication + be generation, load
//   extraction/extension; instantiated once, FSM/counter/registers stay in this module.
// TESTING
//  SW a=0x100 d=0xDEADBEEF, ready 1st ACCESS cycle -> be=1111 wdata=0xDEADBEEF, StallM 2 cycles.
//  SB a=0x103 d=0x000000A5 -> addr=0x100 be=1000 wdata=0xA5A5A5A5.
//  LB a=0x102 rdata=0x0080FF00 -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080; LH a=0x102 -> 0x00000080.
//  LW, ready delayed 3 cycles -> req/addr stable 4 cycles, DONE next, no second request.
//  MAX_WAIT=4, ready never -> BusErrM pulse after 4 ACCESS cycles, StallM released, req low.
//  reset=0 mid-ACCESS -> req=0 immediately, IDLE; LH a=0x101: macro on -> MisalignM, no req;
//   off -> req addr=0x100 be=0011.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the M-stage load/store unit: Funct3 access-size
//   codes, FSM state encoding, byte-enable patterns and a misalignment helper.
package mem_stage_pkg;

  // Funct3 access size / sign codes; codes not listed here are handled as word.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable base patterns, shifted into lane position by the aligner.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Halfwords must sit on an even byte address and words on a word boundary;
  // byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr_lo[0];
      default:     mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Purely combinational byte-lane steering for the M stage.
//   Store side: replicates store data across lanes and builds byte enables
//   from the access size and low address bits (also used for reads).
//   Load side: picks the addressed byte/halfword out of the read word and
//   sign- or zero-extends it.
// Ports
//   st_funct3  in  3   size/sign of the access being issued
//   st_addr_lo in  2   low address bits of the access being issued
//   st_data    in  32  LSB-aligned store data
//   st_wdata   out 32  lane-replicated store data
//   st_be      out 4   byte enables
//   ld_funct3  in  3   size/sign of the outstanding load
//   ld_addr_lo in  2   low address bits of the outstanding load
//   ld_rdata   in  32  raw word from memory
//   ld_data    out 32  extracted and extended load result
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_be    = BE_WORD;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = BE_BYTE << st_addr_lo;
      end
      F3_H, F3_HU: begin
        st_wdata = {2{st_data[15:0]}};
        // a[0] is ignored here; trapping (when enabled) happens upstream.
        st_be    = BE_HALF << {st_addr_lo[1], 1'b0};
      end
      default: begin
        st_wdata = st_data;
        st_be    = BE_WORD;
      end
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  end

  always_comb begin
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   M-stage load/store unit. Captures an access from the EX/MEM register,
//   issues it on a ready/valid data-memory port, stalls the pipeline until
//   the memory answers (or a wait timeout fires) and presents the extended
//   load result for the MEM/WB register.
//   Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses are
//   not issued; MisalignM pulses instead. Without it MisalignM is 0 and low
//   address bits below the access size are ignored.
// Parameters
//   MAX_WAIT     cycles allowed in ACCESS without dmem_ready (1..255)
// Ports
//   clk, reset                 clock / async active-low reset
//   MemReadM, MemWriteM        load / store present in M
//   Funct3M, ALUResultM        size/sign code, byte address
//   WriteDataM                 LSB-aligned store data
//   dmem_req/we/addr/wdata/be  memory request (held stable while pending)
//   dmem_ready, dmem_rdata     memory completion and read data
//   ReadDataM                  extended load result, valid in DONE
//   StallM                     pipeline freeze
//   BusErrM, MisalignM         one-cycle error pulses in DONE
//
// state  | meaning
// IDLE   | no access in flight; a new load/store here stalls and is captured
// ACCESS | request on the bus, waiting for dmem_ready or timeout
// DONE   | one cycle: stall released, result/error flags valid
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        MisalignM
);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  mem_state_e  state;
  logic [7:0]  wait_cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        misalign_q;
  logic        access_m;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign access_m   = MemReadM | MemWriteM;
  assign misaligned = TrapEn & is_misaligned(Funct3M, ALUResultM[1:0]);

  // The stall must be visible in the same cycle the access appears, so it
  // is decoded from state and inputs rather than registered. Gated by reset
  // so the pipeline is never frozen while the unit is held in reset.
  assign StallM = reset & (((state == ST_IDLE) & access_m) | (state == ST_ACCESS));

  assign MisalignM = TrapEn & misalign_q;

  mem_lane_align u_align (
    .st_funct3  (Funct3M),
    .st_addr_lo (ALUResultM[1:0]),
    .st_data    (WriteDataM),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_rdata   (dmem_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= BE_NONE;
      ReadDataM  <= '0;
      wait_cnt   <= '0;
      funct3_q   <= F3_W;
      addr_lo_q  <= 2'b00;
      BusErrM    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      BusErrM    <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access_m) begin
            if (misaligned) begin
              // Trapped access never reaches the bus.
              ReadDataM  <= '0;
              misalign_q <= 1'b1;
              state      <= ST_DONE;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= MemWriteM;   // store wins if both are set
              dmem_addr  <= {ALUResultM[31:2], 2'b00};
              dmem_wdata <= st_wdata;
              dmem_be    <= st_be;
              funct3_q   <= Funct3M;
              addr_lo_q  <= ALUResultM[1:0];
              wait_cnt   <= '0;
              state      <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              ReadDataM <= ld_data;
            end
            state <= ST_DONE;
          end else if (wait_cnt == WaitLast) begin
            dmem_req  <= 1'b0;
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          // EX/MEM advances this cycle; the old access is never re-issued.
          state <= ST_IDLE;
        end
        default: begin
          dmem_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BusErrM;
  logic        MisalignM;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic        req;
    int          req_cycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        buserr;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .BusErrM    (BusErrM),
    .MisalignM  (MisalignM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  // Issues one access at the current negedge, acts as the memory (ready
  // after 'delay' request cycles, never if delay<0), then checks the
  // scoreboard entry when the unit reaches DONE and the idle cycle after.
  task automatic run_op(input string name, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] mem_rdata, input int delay,
                        input logic e_req, input int e_cycles, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata, input logic e_buserr, input logic e_mis);
    exp_t e, got;
    int cyc, rcnt, req_cyc, stall_cyc;
    logic seen;
    logic done;
    logic [31:0] a0, w0;
    logic [3:0] b0;
    logic we0;
    e = '{we: wr, req: e_req, req_cycles: e_cycles, addr: e_addr, be: e_be,
          wdata: e_wdata, rdata: e_rdata, buserr: e_buserr, mis: e_mis};
    sb.push_back(e);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = d;
    #1;
    n_vec++;
    if (StallM !== 1'b1) begin
      n_err++; $display("FAIL %s stall_issue: got %b required 1", name, StallM);
    end
    stall_cyc = 1; req_cyc = 0; rcnt = 0; seen = 1'b0; done = 1'b0; cyc = 0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dmem_req === 1'b1) begin
        req_cyc++;
        if (!seen) begin
          seen = 1'b1; a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be; we0 = dmem_we;
        end else begin
          n_vec++;
          if (dmem_addr !== a0 || dmem_be !== b0 || dmem_wdata !== w0 || dmem_we !== we0) begin
            n_err++; $display("FAIL %s req_stable: got addr=%h be=%b, required addr=%h be=%b",
                              name, dmem_addr, dmem_be, a0, b0);
          end
        end
        if (delay >= 0 && rcnt == delay) begin
          dmem_ready = 1'b1; dmem_rdata = mem_rdata;
        end else begin
          dmem_ready = 1'b0; dmem_rdata = 32'h0BAD0BAD;
        end
        rcnt++;
      end else begin
        dmem_ready = 1'b0;
        if (StallM === 1'b0) done = 1'b1;
      end
      if (StallM === 1'b1) stall_cyc++;
    end
    got = sb.pop_front();
    n_vec++;
    if (!done) begin
      n_err++; $display("FAIL %s done_timeout: got no DONE in 40 cycles, required DONE", name);
    end else begin
      if (seen !== got.req) begin
        n_err++; $display("FAIL %s req_seen: got %b required %b", name, seen, got.req);
      end
      if (got.req && seen) begin
        n_vec++;
        if (a0 !== got.addr || b0 !== got.be || we0 !== got.we) begin
          n_err++; $display("FAIL %s req_fields: got addr=%h be=%b we=%b required addr=%h be=%b we=%b",
                            name, a0, b0, we0, got.addr, got.be, got.we);
        end
        if (got.we) begin
          n_vec++;
          if (w0 !== got.wdata) begin
            n_err++; $display("FAIL %s wdata: got %h required %h", name, w0, got.wdata);
          end
        end
      end
      n_vec++;
      if (req_cyc != got.req_cycles || stall_cyc != got.req_cycles + 1) begin
        n_err++; $display("FAIL %s cycles: got req=%0d stall=%0d required req=%0d stall=%0d",
                          name, req_cyc, stall_cyc, got.req_cycles, got.req_cycles + 1);
      end
      if (!got.we) begin
        n_vec++;
        if (ReadDataM !== got.rdata) begin
          n_err++; $display("FAIL %s ReadDataM: got %h required %h", name, ReadDataM, got.rdata);
        end
      end
      n_vec++;
      if (BusErrM !== got.buserr || MisalignM !== got.mis) begin
        n_err++; $display("FAIL %s flags: got buserr=%b mis=%b required buserr=%b mis=%b",
                          name, BusErrM, MisalignM, got.buserr, got.mis);
      end
    end
    MemReadM = 1'b0; MemWriteM = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dmem_req !== 1'b0 || StallM !== 1'b0 || BusErrM !== 1'b0 || MisalignM !== 1'b0) begin
      n_err++; $display("FAIL %s after_done: got req=%b stall=%b buserr=%b mis=%b required all 0",
                        name, dmem_req, StallM, BusErrM, MisalignM);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b010;
    ALUResultM = '0; WriteDataM = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || StallM !== 1'b0 || BusErrM !== 1'b0 || MisalignM !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got req=%b we=%b stall=%b buserr=%b mis=%b required all 0",
                        dmem_req, dmem_we, StallM, BusErrM, MisalignM);
    end
    n_vec++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || ReadDataM !== 32'h0 || dmem_be !== 4'b0000) begin
      n_err++; $display("FAIL reset_data: got addr=%h wdata=%h rd=%h be=%b required zeros",
                        dmem_addr, dmem_wdata, ReadDataM, dmem_be);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stores();
    run_op("sw",  1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
           1'b1, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    run_op("sb",  1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0,
           1'b1, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
    run_op("sh_both", 1'b1, 1'b1, 3'b001, 32'h12, 32'h1234BEEF, 32'h0, 1,
           1'b1, 2, 32'h10, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_loads();
    run_op("lb",  1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0,
           1'b1, 1, 32'h100, 4'b0100, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    run_op("lbu", 1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0,
           1'b1, 1, 32'h100, 4'b0100, 32'h0, 32'h00000080, 1'b0, 1'b0);
    run_op("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0080FF00, 0,
           1'b1, 1, 32'h100, 4'b1100, 32'h0, 32'h00000080, 1'b0, 1'b0);
    run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 32'h80010000, 0,
           1'b1, 1, 32'h104, 4'b1100, 32'h0, 32'h00008001, 1'b0, 1'b0);
    run_op("f3_011_as_w", 1'b1, 1'b0, 3'b011, 32'h44, 32'h0, 32'hCAFEF00D, 0,
           1'b1, 1, 32'h44, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
  endtask

  task automatic test_delayed_ready();
    run_op("lw_delay3", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 3,
           1'b1, 4, 32'h200, 4'b1111, 32'h0, 32'h12345678, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h55555555, -1,
           1'b1, 4, 32'h300, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'hAAAA8001, 0,
           1'b0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
`else
    run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'hAAAA8001, 0,
           1'b1, 1, 32'h100, 4'b0011, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_access();
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h400;
    dmem_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dmem_req !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_req_up: got %b required 1", dmem_req);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (dmem_req !== 1'b0 || StallM !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_drop: got req=%b stall=%b required 0 0", dmem_req, StallM);
    end
    @(negedge clk);
    MemReadM = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dmem_req !== 1'b0 || StallM !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_idle: got req=%b stall=%b required 0 0", dmem_req, StallM);
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_delayed_ready();
    test_timeout();
    test_misalign();
    test_reset_mid_access();
    test_stores();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
